// File: rtl/pb_pkg.sv
// Shared definitions for the push-button conditioner: state encoding,
// default parameter values and the auto-repeat counter width.
// The counter that uses REP_CNT_W exists only when AUTO_REPEAT_EN is defined.
package pb_pkg;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } pb_state_e;

  localparam int DEF_NUM_SAMPLES   = 4;
  localparam int DEF_REPEAT_DELAY  = 8;
  localparam int DEF_REPEAT_PERIOD = 2;
  localparam int REP_CNT_W         = 8;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser with synchronous active-high reset.
// Brings an asynchronous level into the clk domain with two cycles of delay.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pb_debounce_onepulse.sv
// Push-button conditioner: synchronises a bouncy button and the slow
// clk_debounce square wave, samples the button once per clk_debounce rising
// edge into a NUM_SAMPLES-deep window, and runs a two-state FSM that gives a
// clean level (pb_debounced) and a one-cycle press strobe (pb_pulse).
// clk_debounce is only ever sampled as data; everything runs on clk.
// Optional build macro AUTO_REPEAT_EN adds held-button auto-repeat pulses
// after REPEAT_DELAY ticks and then every REPEAT_PERIOD ticks.
module pb_debounce_onepulse
  import pb_pkg::*;
#(
  parameter int NUM_SAMPLES   = DEF_NUM_SAMPLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_debounce,
  input  logic pb_in,
  output logic pb_debounced,
  output logic pb_pulse
);

  // Reject parameter values the window and repeat logic cannot handle.
  if (NUM_SAMPLES < 2 || NUM_SAMPLES > 8) begin : g_bad_num_samples
    $error("NUM_SAMPLES must lie in 2..8");
  end
  if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_bad_repeat_sign
    $error("REPEAT_DELAY and REPEAT_PERIOD must be non-negative");
  end

  logic                   w_pb_sync;
  logic                   w_dbc_sync;
  logic                   r_dbc_prev;
  logic                   w_tick;
  logic [NUM_SAMPLES-1:0] r_window;
  logic                   w_win_ones;
  logic                   w_win_zeros;
  pb_state_e              r_state;
  pb_state_e              w_state_nxt;
  logic                   w_press_edge;
  logic                   w_rep_hit;
  logic                   r_pulse;

  sync_2ff u_sync_pb (
    .clk (clk),
    .rst (rst),
    .i_d (pb_in),
    .o_q (w_pb_sync)
  );

  sync_2ff u_sync_dbc (
    .clk (clk),
    .rst (rst),
    .i_d (clk_debounce),
    .o_q (w_dbc_sync)
  );

  // Delay the synchronised clk_debounce by one cycle for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dbc_prev <= 1'b0;
    end else begin
      r_dbc_prev <= w_dbc_sync;
    end
  end

  assign w_tick = w_dbc_sync & ~r_dbc_prev;

  // Shift the synchronised button level into the window once per tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_window <= '0;
    end else if (w_tick) begin
      r_window <= {r_window[NUM_SAMPLES-2:0], w_pb_sync};
    end
  end

  // A bounce anywhere in the window breaks "all equal", so the count restarts
  // without needing an explicit counter.
  assign w_win_ones  = &r_window;
  assign w_win_zeros = ~|r_window;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RELEASED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic: change only when the whole window agrees.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RELEASED: if (w_win_ones)  w_state_nxt = PRESSED;
      PRESSED:  if (w_win_zeros) w_state_nxt = RELEASED;
      default:  w_state_nxt = RELEASED;
    endcase
  end

  // FSM output decode: flag the transition into PRESSED.
  always_comb begin
    w_press_edge = 1'b0;
    if (r_state == RELEASED && w_state_nxt == PRESSED) begin
      w_press_edge = 1'b1;
    end
  end

`ifdef AUTO_REPEAT_EN
  if (REPEAT_DELAY < 1 || REPEAT_DELAY >= (1 << REP_CNT_W) ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
    $error("REPEAT_DELAY/REPEAT_PERIOD out of range for auto-repeat");
  end

  localparam logic [REP_CNT_W-1:0] REP_DELAY_C  = REP_CNT_W'(REPEAT_DELAY);
  // Reloading here makes the counter reach REP_DELAY_C again after
  // REPEAT_PERIOD more ticks.
  localparam logic [REP_CNT_W-1:0] REP_RELOAD_C = REP_CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [REP_CNT_W-1:0] r_rep_cnt;
  logic [REP_CNT_W-1:0] w_rep_cnt_inc;

  assign w_rep_cnt_inc = r_rep_cnt + REP_CNT_W'(1);
  assign w_rep_hit     = w_tick && (r_state == PRESSED) && (w_rep_cnt_inc == REP_DELAY_C);

  // Count ticks while held; idle at zero whenever the button is not PRESSED.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_cnt <= '0;
    end else if (r_state != PRESSED) begin
      r_rep_cnt <= '0;
    end else if (w_tick) begin
      r_rep_cnt <= w_rep_hit ? REP_RELOAD_C : w_rep_cnt_inc;
    end
  end
`else
  assign w_rep_hit = 1'b0;
`endif

  // Register the strobe so it lines up with the first PRESSED cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_press_edge | w_rep_hit;
    end
  end

  assign pb_debounced = (r_state == PRESSED);
  assign pb_pulse     = r_pulse;

endmodule
